// File: rtl/unidade_controle_jogo_timeout_if.sv
// unidade_controle_jogo_timeout_if: control-unit <-> datapath signal bundle of the memory game
interface unidade_controle_jogo_timeout_if;
  logic       jogar, jogada, igual, enderecoIgualRodada, fimJogo;
  logic       zeraE, contaE, zeraR, contaR, registraR;
  logic       ganhou, perdeu, pronto, db_timeout;
  logic [3:0] db_estado;
  modport master (
    output jogar, jogada, igual, enderecoIgualRodada, fimJogo,
    input  zeraE, contaE, zeraR, contaR, registraR, ganhou, perdeu, pronto, db_timeout, db_estado
  );
  modport slave (
    input  jogar, jogada, igual, enderecoIgualRodada, fimJogo,
    output zeraE, contaE, zeraR, contaR, registraR, ganhou, perdeu, pronto, db_timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_timeout.sv
// unidade_controle_jogo_timeout: memory-game control FSM with its own per-play timeout counter
module unidade_controle_jogo_timeout #(
  parameter int TIMEOUT_CICLOS = 150000000
) (
  input logic                          clock,
  input logic                          reset,
  unidade_controle_jogo_timeout_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIO_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROX_JOGADA   = 4'h6,
    PROX_RODADA   = 4'h7,
    FIM_ACERTO    = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERRO      = 4'hE
  } estado_t;
  estado_t       r_estado, w_proximo;
  logic [TW-1:0] r_timer;
  logic          w_fim_timer;
  assign w_fim_timer = r_timer == TW'(TIMEOUT_CICLOS - 1);
  // timer clears on leaving ESPERA so it can never run past the terminal count
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_estado <= INICIAL;
      r_timer  <= '0;
    end else begin
      r_estado <= w_proximo;
      r_timer  <= (r_estado == ESPERA && w_proximo == ESPERA) ? r_timer + 1'b1 : '0;
    end
  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:       w_proximo = bus.jogar ? PREPARA : INICIAL;
      PREPARA:       w_proximo = INICIO_RODADA;
      INICIO_RODADA: w_proximo = ESPERA;
      ESPERA:        w_proximo = bus.jogada ? REGISTRA : w_fim_timer ? FIM_TIMEOUT : ESPERA;
      REGISTRA:      w_proximo = COMPARA;
      COMPARA:       w_proximo = !bus.igual ? FIM_ERRO :
                                 !bus.enderecoIgualRodada ? PROX_JOGADA :
                                 bus.fimJogo ? FIM_ACERTO : PROX_RODADA;
      PROX_JOGADA:   w_proximo = ESPERA;
      PROX_RODADA:   w_proximo = INICIO_RODADA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: w_proximo = bus.jogar ? PREPARA : r_estado;
      default:       w_proximo = INICIAL;
    endcase
  end
  assign bus.zeraE      = r_estado == PREPARA || r_estado == INICIO_RODADA;
  assign bus.zeraR      = r_estado == PREPARA;
  assign bus.contaE     = r_estado == PROX_JOGADA;
  assign bus.contaR     = r_estado == PROX_RODADA;
  assign bus.registraR  = r_estado == REGISTRA;
  assign bus.ganhou     = r_estado == FIM_ACERTO;
  assign bus.perdeu     = r_estado == FIM_ERRO || r_estado == FIM_TIMEOUT;
  assign bus.pronto     = r_estado == FIM_ACERTO || r_estado == FIM_ERRO || r_estado == FIM_TIMEOUT;
  assign bus.db_timeout = r_estado == FIM_TIMEOUT;
  assign bus.db_estado  = r_estado;
endmodule

// File: tb/tb_unidade_controle_jogo_timeout.sv
// tb_unidade_controle_jogo_timeout: scoreboard bench, stimulus queues expected outputs, monitor compares
module tb_unidade_controle_jogo_timeout;
  logic clock = 1'b0;
  logic reset = 1'b1;
  unidade_controle_jogo_timeout_if bus();
  unidade_controle_jogo_timeout #(.TIMEOUT_CICLOS(20)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [7:0]  id;
    logic [12:0] v;
  } exp_t;
  exp_t       q[$];
  int         n_chk = 0, n_fail = 0, cnt_e = 0, cnt_r = 0;
  logic [7:0] phase = 8'd0;
  event       ev_async;
  logic [12:0] act;
  assign act = {bus.db_estado, bus.zeraE, bus.contaE, bus.zeraR, bus.contaR, bus.registraR,
                bus.ganhou, bus.perdeu, bus.pronto, bus.db_timeout};
  // expected output word per state: {code, zeraE contaE zeraR contaR registraR ganhou perdeu pronto db_timeout}
  function automatic logic [12:0] ev(input logic [3:0] s);
    logic [8:0] o;
    case (s)
      4'h1:    o = 9'b101000000;
      4'h2:    o = 9'b100000000;
      4'h4:    o = 9'b000010000;
      4'h6:    o = 9'b010000000;
      4'h7:    o = 9'b000100000;
      4'hA:    o = 9'b000001010;
      4'hD:    o = 9'b000000111;
      4'hE:    o = 9'b000000110;
      default: o = 9'b000000000;
    endcase
    return {s, o};
  endfunction
  task automatic push(input logic [3:0] s);
    exp_t e;
    e.id = phase;
    e.v  = ev(s);
    q.push_back(e);
  endtask
  task automatic step(input logic [3:0] s);
    @(posedge clock);
    #1;
    push(s);
  endtask
  task automatic chk_int(input string name, input int a, input int x);
    n_chk++;
    if (a != x) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, x);
    end
  endtask
  // caller has just stepped into ESPERA; w idle cycles precede the jogada pulse
  task automatic play(input int w, input logic ig, input logic eir, input logic fim, input logic [3:0] nx);
    repeat (w) step(4'h3);
    bus.jogada = 1'b1;
    step(4'h4);
    bus.jogada = 1'b0;
    bus.igual = ig;
    bus.enderecoIgualRodada = eir;
    bus.fimJogo = fim;
    step(4'h5);
    step(nx);
    bus.igual = 1'b1;
    bus.enderecoIgualRodada = 1'b0;
    bus.fimJogo = 1'b0;
    if (nx == 4'h6) step(4'h3);
    else if (nx == 4'h7) begin
      step(4'h2);
      step(4'h3);
    end
  endtask
  task automatic start();
    bus.jogar = 1'b1;
    step(4'h1);
    bus.jogar = 1'b0;
    step(4'h2);
    step(4'h3);
  endtask
  task automatic rounds(input int n);
    for (int r = 0; r < n; r++)
      for (int e = 0; e <= r; e++)
        play(0, 1'b1, e == r, r == 15, e < r ? 4'h6 : r == 15 ? 4'hA : 4'h7);
  endtask
  task automatic async_rst();
    @(negedge clock);
    #1;
    reset = 1'b1;
    bus.jogar = 1'b0;
    #1;
    push(4'h0);
    ->ev_async;
    step(4'h0);
    reset = 1'b0;
    step(4'h0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or ev_async);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL state phase %0d: got %h expected %h", e.id, act, e.v);
        end
      end
    end
  end
  always @(negedge clock) begin
    if (bus.contaE === 1'b1) cnt_e <= cnt_e + 1;
    if (bus.contaR === 1'b1) cnt_r <= cnt_r + 1;
  end
  initial begin
    int be, br;
    bus.jogar = 1'b0;
    bus.jogada = 1'b0;
    bus.igual = 1'b1;
    bus.enderecoIgualRodada = 1'b0;
    bus.fimJogo = 1'b0;
    step(4'h0);
    step(4'h0);
    reset = 1'b0;
    step(4'h0);
    phase = 8'd1;
    start();
    async_rst();
    start();
    phase = 8'd2;
    be = cnt_e;
    br = cnt_r;
    rounds(16);
    repeat (3) step(4'hA);
    chk_int("contaE pulses", cnt_e - be, 120);
    chk_int("contaR pulses", cnt_r - br, 15);
    phase = 8'd3;
    start();
    rounds(2);
    play(0, 1'b1, 1'b0, 1'b0, 4'h6);
    play(0, 1'b0, 1'b0, 1'b0, 4'hE);
    repeat (2) step(4'hE);
    phase = 8'd4;
    start();
    rounds(2);
    play(18, 1'b1, 1'b0, 1'b0, 4'h6);
    play(19, 1'b1, 1'b0, 1'b0, 4'h6);
    play(19, 1'b1, 1'b1, 1'b0, 4'h7);
    play(0, 1'b1, 1'b0, 1'b0, 4'h6);
    repeat (19) step(4'h3);
    step(4'hD);
    repeat (2) step(4'hD);
    phase = 8'd5;
    bus.jogar = 1'b1;
    step(4'h1);
    step(4'h2);
    step(4'h3);
    repeat (10) step(4'h3);
    async_rst();
    start();
    repeat (19) step(4'h3);
    step(4'hD);
    step(4'hD);
    @(negedge clock);
    #1;
    chk_int("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
